// File: rtl/core_cmd_issuer.sv
// core_cmd_issuer: host command/byte front end feeding core op and image-byte handshakes.
// Optional ISSUER_PERF_EN adds saturating stall/starve counters.
module core_cmd_issuer #(
  parameter int IMG_BYTES = 2048,
  parameter int CNT_W     = 11,
  parameter int CMD_CNT_W = 10
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cmd_valid,
  input  logic [3:0]           i_cmd_mode,
  output logic                 o_cmd_ready,
  input  logic                 i_byte_valid,
  input  logic [7:0]           i_byte_data,
  output logic                 o_byte_ready,
  input  logic                 i_op_ready,
  output logic                 o_op_valid,
  output logic [3:0]           o_op_mode,
  input  logic                 i_in_ready,
  output logic                 o_in_valid,
  output logic [7:0]           o_in_data,
  output logic                 o_busy,
  output logic [CMD_CNT_W-1:0] o_cmd_cnt
`ifdef ISSUER_PERF_EN
  ,
  output logic [15:0]          o_stall_cnt,
  output logic [15:0]          o_starve_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, ISSUE, LOAD} state_t;
  localparam logic [CNT_W:0]   IMG_N = (CNT_W+1)'(IMG_BYTES);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(IMG_BYTES - 1);
  state_t               state_q, state_d;
  logic [3:0]           mode_q, mode_d, op_mode_q, op_mode_d;
  logic                 armed_q, armed_d, op_valid_q, op_valid_d;
  logic [CMD_CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
  logic [7:0]           mem_q [2];
  logic [7:0]           mem_d [2];
  logic                 wr_q, wr_d, rd_q, rd_d;
  logic [1:0]           occ_q, occ_d;
  logic [CNT_W-1:0]     byte_q, byte_d;
  logic [CNT_W:0]       acc_q, acc_d;
  logic                 push, pop, done, in_load;
  assign in_load      = state_q == LOAD;
  assign o_cmd_ready  = state_q == IDLE && armed_q;
  assign o_byte_ready = in_load && occ_q != 2'd2 && acc_q < IMG_N;
  assign o_in_valid   = occ_q != 2'd0;
  assign o_in_data    = mem_q[rd_q];
  assign o_op_valid   = op_valid_q;
  assign o_op_mode    = op_mode_q;
  assign o_busy       = state_q != IDLE;
  assign o_cmd_cnt    = cmd_cnt_q;
  assign push         = i_byte_valid && o_byte_ready;
  assign pop          = in_load && o_in_valid && i_in_ready;
  assign done         = pop && byte_q == LAST;
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    armed_d    = armed_q | i_op_ready;
    op_valid_d = 1'b0;
    op_mode_d  = op_mode_q;
    cmd_cnt_d  = cmd_cnt_q;
    mem_d      = mem_q;
    wr_d       = wr_q ^ push;
    rd_d       = rd_q ^ pop;
    occ_d      = occ_q + 2'(push) - 2'(pop);
    byte_d     = done ? '0 : byte_q + CNT_W'(pop);
    acc_d      = done ? '0 : acc_q + (CNT_W+1)'(push);
    if (push) mem_d[wr_q] = i_byte_data;
    if (state_q == IDLE && i_cmd_valid && o_cmd_ready) begin
      mode_d  = i_cmd_mode;
      state_d = ISSUE;
    end
    if (state_q == ISSUE) begin
      op_valid_d = 1'b1;
      op_mode_d  = mode_q;
      armed_d    = i_op_ready;
      cmd_cnt_d  = cmd_cnt_q + CMD_CNT_W'(1);
      state_d    = mode_q == 4'd0 ? LOAD : IDLE;
    end
    if (done) state_d = IDLE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      mode_q     <= '0;
      armed_q    <= 1'b0;
      op_valid_q <= 1'b0;
      op_mode_q  <= '0;
      cmd_cnt_q  <= '0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      occ_q      <= '0;
      byte_q     <= '0;
      acc_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      armed_q    <= armed_d;
      op_valid_q <= op_valid_d;
      op_mode_q  <= op_mode_d;
      cmd_cnt_q  <= cmd_cnt_d;
      mem_q      <= mem_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      occ_q      <= occ_d;
      byte_q     <= byte_d;
      acc_q      <= acc_d;
    end
  end
`ifdef ISSUER_PERF_EN
  logic [15:0] stall_q, stall_d, starve_q, starve_d;
  assign o_stall_cnt  = stall_q;
  assign o_starve_cnt = starve_q;
  always_comb begin
    stall_d  = in_load && o_in_valid && !i_in_ready && stall_q != 16'hFFFF ? stall_q + 16'd1 : stall_q;
    starve_d = in_load && !o_in_valid && starve_q != 16'hFFFF ? starve_q + 16'd1 : starve_q;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      stall_q  <= '0;
      starve_q <= '0;
    end else begin
      stall_q  <= stall_d;
      starve_q <= starve_d;
    end
  end
`endif
endmodule
